fir_channel_scheduler: RTL and testbench
========================================

Name: fir_channel_scheduler

Overview:
- Sequences up to CHANNELS independent sample streams into the shared time-multiplexed multi-channel FIR filter.
- Buffers one sample per channel and arbitrates access to the FIR input port.
- Arbitration is either round-robin (free mode) or ordered bursts of one sample per enabled channel (sync mode).
- Demultiplexes the FIR output back into per-channel result registers and flags frame completion.

Parameters:
CHANNELS, 4, number of streams; FIR channel index width CW = clog2(CHANNELS), minimum 1
DATA_WIDTH, 16, sample/result width (two's complement, passed through unmodified)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ch_valid  in  CHANNELS  per-channel sample valid
ch_data  in  CHANNELS*DATA_WIDTH  per-channel sample; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
ch_ready  out  CHANNELS  per-channel slot free
enable_mask  in  CHANNELS  1 = channel participates
sync_mode  in  1  0 = free round-robin, 1 = synchronous burst
fir_in_ready  in  1  FIR accepts input
fir_in_valid  out  1  request to FIR
fir_in_data  out  DATA_WIDTH  sample to FIR
fir_in_channel  out  CW  channel tag to FIR
fir_out_valid  in  1  FIR result valid
fir_out_channel  in  CW  FIR result tag
fir_out_data  in  DATA_WIDTH  FIR result
result_data  out  CHANNELS*DATA_WIDTH  last result per channel
result_update  out  CHANNELS  one-cycle pulse per stored result
frame_done  out  1  one-cycle pulse when all results of a sync burst have returned

Behaviour:
- Reset (async, reset=0): all slots empty; fir_in_valid=0; fir_in_data=0; fir_in_channel=0; result_data=0; result_update=0; frame_done=0; RR pointer=0; state=IDLE. Asserting reset mid-transfer aborts it; buffered samples are discarded.
- Slots: ch_ready[i] = !slot_full[i] | !enable_mask[i] (combinational).
  - Enabled i: ch_valid & ch_ready loads slot; full from next cycle.
  - Disabled i: input is accepted and dropped.
  - Clearing enable_mask[i] does not flush a full slot; it is still issued in free mode.
- FIR handshake: fir_in_valid/fir_in_data/fir_in_channel are registered and held stable until the cycle with fir_in_valid & fir_in_ready. At that posedge the granted slot is cleared. If another eligible slot is full, the next request is presented in the following cycle, so back-to-back transfers are allowed. No same-cycle refill of the granted slot.
- Free mode (sync_mode=0), states IDLE/ISSUE:
  - IDLE: pick the first full slot searching from RR pointer; go to ISSUE.
  - On transfer, RR pointer = granted+1 mod CHANNELS.
  - Channels with CHANNELS non-power-of-two: indices >= CHANNELS are never issued.
- Sync mode (sync_mode=1), states WAIT_ALL/BURST:
  - WAIT_ALL: latch mask = enable_mask each cycle. When the mask is non-zero and every masked slot is full, go to BURST.
  - BURST: issue masked channels in ascending index, one transfer each; then back to WAIT_ALL.
  - Mask of zero: stay in WAIT_ALL.
- sync_mode is sampled only when fir_in_valid=0 and not in BURST; a change mid-burst takes effect after the burst.
- Output demux: on fir_out_valid, result_data[fir_out_channel] <= fir_out_data and result_update[fir_out_channel]=1 for exactly the next cycle. Out-of-range tag: ignored.
- Outstanding counter, set to popcount(mask) at burst start:
  - Decrements on each fir_out_valid whose tag is in the mask.
  - Reaching 0 pulses frame_done one cycle after the last result.
  - A new burst starting while the count is non-zero reloads it; the old frame_done is lost by design.
  - Free mode never pulses frame_done.
- Simultaneous ch_valid on all channels: all slots load in the same cycle; arbitration serialises them.

Test Plan:
- Free mode, mask=4'b1111, fir_in_ready=1, all four ch_valid with 32767 in one cycle -> four transfers on consecutive cycles, channels 0,1,2,3. Each slot's ch_ready returns high the cycle after its transfer.
- Free mode, fir_in_ready held 0 for 5 cycles with channel 2 full -> fir_in_valid=1, fir_in_channel=2, data stable all 5 cycles; transfer on first ready cycle.
- Sync mode, mask=4'b1011, channels 3 then 0 then 1 written at cycles 0/3/6 (value -32768) -> no fir_in_valid before cycle 7; burst order 0,1,3; frame_done after the third matching fir_out_valid; channel 2 input dropped with ch_ready=1.
- fir_out_valid with tag 1, data 0x1234 -> result_data[1]=0x1234; result_update=4'b0010 for exactly one cycle.
- Round-robin fairness: channels 0 and 1 refilled every cycle, fir_in_ready=1 -> grants alternate 0,1,0,1.
- Reset asserted while fir_in_valid=1 and fir_in_ready=0 -> fir_in_valid drops immediately. After release, no transfer until new ch_valid.

Source files
------------

// File: rtl/fir_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_channel_scheduler_if
//  Purpose  : Bundles the per-channel sample inputs, the FIR input/output
//             handshakes and the demultiplexed result outputs of the
//             multi-channel FIR scheduler.
//  Modports : master - scheduler side (drives ch_ready, fir_in_*, result_*,
//                      frame_done)
//             slave  - environment side (drives ch_*, enable_mask, sync_mode,
//                      fir_in_ready, fir_out_*)
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_channel_scheduler_if #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS-1:0]            ch_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] ch_data;
    logic [CHANNELS-1:0]            ch_ready;
    logic [CHANNELS-1:0]            enable_mask;
    logic                           sync_mode;
    logic                           fir_in_ready;
    logic                           fir_in_valid;
    logic [DATA_WIDTH-1:0]          fir_in_data;
    logic [CW-1:0]                  fir_in_channel;
    logic                           fir_out_valid;
    logic [CW-1:0]                  fir_out_channel;
    logic [DATA_WIDTH-1:0]          fir_out_data;
    logic [CHANNELS*DATA_WIDTH-1:0] result_data;
    logic [CHANNELS-1:0]            result_update;
    logic                           frame_done;

    modport master (
        input  ch_valid, ch_data, enable_mask, sync_mode, fir_in_ready,
               fir_out_valid, fir_out_channel, fir_out_data,
        output ch_ready, fir_in_valid, fir_in_data, fir_in_channel,
               result_data, result_update, frame_done
    );

    modport slave (
        output ch_valid, ch_data, enable_mask, sync_mode, fir_in_ready,
               fir_out_valid, fir_out_channel, fir_out_data,
        input  ch_ready, fir_in_valid, fir_in_data, fir_in_channel,
               result_data, result_update, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fir_channel_scheduler
//  Purpose  : Buffers one sample per channel, arbitrates the shared FIR input
//             (round-robin in free mode, ordered bursts in sync mode) and
//             demultiplexes FIR results into per-channel result registers.
//  Ports    : clk   - system clock
//             reset - asynchronous, active-low reset
//             bus   - fir_channel_scheduler_if.master (sample inputs, FIR
//                     input/output handshakes, results, frame_done)
//  Revision : 1.0 - initial release
// ============================================================================
module fir_channel_scheduler #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_channel_scheduler_if.master bus
);
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_CNT_W = CW + 1;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ISSUE    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_ALL = 2'd2;
    localparam logic [1:0] c_ST_BURST    = 2'd3;

    logic [1:0]                     state_q, state_d;
    logic [CHANNELS-1:0]            slot_full_q, slot_full_d;
    logic [DATA_WIDTH-1:0]          slot_data_q [CHANNELS];
    logic [CW-1:0]                  rr_q, rr_d;
    logic                           fir_valid_q, fir_valid_d;
    logic [DATA_WIDTH-1:0]          fir_data_q, fir_data_d;
    logic [CW-1:0]                  fir_chan_q, fir_chan_d;
    logic [CHANNELS-1:0]            mask_q, mask_d;     // sync-mode mask
    logic [CHANNELS-1:0]            pend_q, pend_d;     // burst channels not yet presented
    logic [CHANNELS-1:0]            fmask_q, fmask_d;   // channels counted toward frame_done
    logic [c_CNT_W-1:0]             cnt_q, cnt_d;
    logic                           done_q, done_d;
    logic [CHANNELS*DATA_WIDTH-1:0] res_q, res_d;
    logic [CHANNELS-1:0]            upd_q, upd_d;

    logic                           w_xfer;
    logic [CHANNELS-1:0]            w_load;
    logic [CHANNELS-1:0]            w_grant_oh;
    logic [CHANNELS-1:0]            w_tag_oh;
    logic [CW-1:0]                  w_rr_next;
    logic [CW:0]                    w_pick;    // {found, index}
    logic                           w_present;

    // First set bit of req at or above start, otherwise the lowest set bit
    // below start (wrap-around). The upper pass overrides the lower one.
    function automatic logic [CW:0] pick_from(input logic [CHANNELS-1:0] req, input int start);
        logic [CW:0] r;
        r = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (req[i] && i < start) r = {1'b1, CW'(i)};
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (req[i] && i >= start) r = {1'b1, CW'(i)};
        return r;
    endfunction

    function automatic logic [CHANNELS-1:0] to_oh(input logic [CW-1:0] idx);
        logic [CHANNELS-1:0] v;
        for (int i = 0; i < CHANNELS; i++) v[i] = (idx == CW'(i));
        return v;
    endfunction

    function automatic logic [c_CNT_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [c_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHANNELS; i++) n = n + c_CNT_W'(v[i]);
        return n;
    endfunction

    assign w_xfer       = fir_valid_q & bus.fir_in_ready;
    assign bus.ch_ready = ~slot_full_q | ~bus.enable_mask;
    // A disabled channel is always ready but never loads: its sample is dropped.
    assign w_load       = bus.ch_valid & bus.enable_mask & ~slot_full_q;

    // Out-of-range result tags match no bit and are therefore ignored.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_onehot
        assign w_grant_oh[gi] = (fir_chan_q == CW'(gi));
        assign w_tag_oh[gi]   = bus.fir_out_valid & (bus.fir_out_channel == CW'(gi));
    end

    assign w_rr_next = (int'(fir_chan_q) < CHANNELS - 1) ? fir_chan_q + CW'(1) : '0;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        fir_valid_d = fir_valid_q;
        fir_chan_d  = fir_chan_q;
        fir_data_d  = fir_data_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        fmask_d     = fmask_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        w_pick      = '0;
        w_present   = 1'b0;
        // The granted slot is cleared on transfer; it is full that cycle so
        // it cannot be refilled at the same edge.
        slot_full_d = (slot_full_q & ~({CHANNELS{w_xfer}} & w_grant_oh)) | w_load;

        if (|(w_tag_oh & fmask_q) && cnt_q != '0) begin
            cnt_d  = cnt_q - c_CNT_W'(1);
            done_d = (cnt_q == c_CNT_W'(1));
        end

        case (state_q)
            c_ST_IDLE: begin
                mask_d = bus.enable_mask;
                if (bus.sync_mode) begin
                    state_d = c_ST_WAIT_ALL;
                end else begin
                    w_pick = pick_from(slot_full_q, int'(rr_q));
                    if (w_pick[CW]) begin
                        w_present = 1'b1;
                        state_d   = c_ST_ISSUE;
                    end
                end
            end
            c_ST_ISSUE: begin
                if (w_xfer) begin
                    rr_d   = w_rr_next;
                    // Chain straight into the next full slot for back-to-back issue.
                    w_pick = pick_from(slot_full_q & ~w_grant_oh, int'(w_rr_next));
                    if (w_pick[CW]) begin
                        w_present = 1'b1;
                    end else begin
                        fir_valid_d = 1'b0;
                        state_d     = c_ST_IDLE;
                    end
                end
            end
            c_ST_WAIT_ALL: begin
                if (!bus.sync_mode) begin
                    // Leaving sync mode abandons any frame still in flight.
                    state_d = c_ST_IDLE;
                    cnt_d   = '0;
                end else if (mask_q != '0 && (slot_full_q & mask_q) == mask_q) begin
                    w_pick    = pick_from(mask_q, 0);
                    w_present = 1'b1;
                    pend_d    = mask_q & ~to_oh(w_pick[CW-1:0]);
                    fmask_d   = mask_q;
                    cnt_d     = popcount(mask_q);
                    state_d   = c_ST_BURST;
                end else begin
                    mask_d = bus.enable_mask;
                end
            end
            default: begin  // c_ST_BURST
                if (w_xfer) begin
                    w_pick = pick_from(pend_q, 0);
                    if (w_pick[CW]) begin
                        w_present = 1'b1;
                        pend_d    = pend_q & ~to_oh(w_pick[CW-1:0]);
                    end else begin
                        fir_valid_d = 1'b0;
                        state_d     = c_ST_WAIT_ALL;
                    end
                end
            end
        endcase

        if (w_present) begin
            fir_valid_d = 1'b1;
            fir_chan_d  = w_pick[CW-1:0];
            for (int i = 0; i < CHANNELS; i++)
                if (w_pick[CW-1:0] == CW'(i)) fir_data_d = slot_data_q[i];
        end
    end

    always_comb begin
        res_d = res_q;
        upd_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_tag_oh[i]) begin
                res_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fir_out_data;
                upd_d[i]                          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= c_ST_IDLE;
            slot_full_q <= '0;
            rr_q        <= '0;
            fir_valid_q <= 1'b0;
            fir_data_q  <= '0;
            fir_chan_q  <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            fmask_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            res_q       <= '0;
            upd_q       <= '0;
        end else begin
            state_q     <= state_d;
            slot_full_q <= slot_full_d;
            rr_q        <= rr_d;
            fir_valid_q <= fir_valid_d;
            fir_data_q  <= fir_data_d;
            fir_chan_q  <= fir_chan_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            fmask_q     <= fmask_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            res_q       <= res_d;
            upd_q       <= upd_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) slot_data_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                if (w_load[i]) slot_data_q[i] <= bus.ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.fir_in_valid   = fir_valid_q;
    assign bus.fir_in_data    = fir_data_q;
    assign bus.fir_in_channel = fir_chan_q;
    assign bus.result_data    = res_q;
    assign bus.result_update  = upd_q;
    assign bus.frame_done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_channel_scheduler
//  Purpose  : Scoreboard bench for fir_channel_scheduler. Stimulus pushes the
//             expected FIR transfers and result updates into queues; a
//             negedge monitor pops and compares them when the DUT presents
//             them. Cycle-exact properties are checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_channel_scheduler;
    localparam int CHANNELS = 4;
    localparam int DW       = 16;
    localparam int CW       = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fir_channel_scheduler_if #(.CHANNELS(CHANNELS), .DATA_WIDTH(DW)) bus ();

    fir_channel_scheduler #(.CHANNELS(CHANNELS), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t xfer_q[$];
    exp_t res_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] v);
        bus.ch_data[ch*DW +: DW] = v;
    endtask

    task automatic fir_result(input logic [CW-1:0] ch, input logic [DW-1:0] v);
        bus.fir_out_valid   = 1'b1;
        bus.fir_out_channel = ch;
        bus.fir_out_data    = v;
        res_q.push_back({ch, v});
    endtask

    // Monitor: compares every FIR transfer and every result update.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.fir_in_valid && bus.fir_in_ready) begin
                if (xfer_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got channel %0d data 0x%0h, expected no transfer",
                             bus.fir_in_channel, bus.fir_in_data);
                end else begin
                    mon_e = xfer_q.pop_front();
                    chk("xfer_channel", 64'(bus.fir_in_channel), 64'(mon_e.ch));
                    chk("xfer_data", 64'(bus.fir_in_data), 64'(mon_e.data));
                end
            end
            if (bus.result_update != '0) begin
                if (res_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL result_unexpected: got update 0x%0h, expected none", bus.result_update);
                end else begin
                    mon_e = res_q.pop_front();
                    chk("result_update", 64'(bus.result_update), 64'(4'b0001 << mon_e.ch));
                    chk("result_data", 64'(bus.result_data[mon_e.ch*DW +: DW]), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        logic [3:0] exp_rdy;
        bus.ch_valid        = '0;
        bus.ch_data         = '0;
        bus.enable_mask     = 4'hF;
        bus.sync_mode       = 1'b0;
        bus.fir_in_ready    = 1'b1;
        bus.fir_out_valid   = 1'b0;
        bus.fir_out_channel = '0;
        bus.fir_out_data    = '0;

        // ---- Reset state ----
        tick(2);
        chk("rst_fir_in_valid", 64'(bus.fir_in_valid), 64'(0));
        chk("rst_fir_in_data", 64'(bus.fir_in_data), 64'(0));
        chk("rst_fir_in_channel", 64'(bus.fir_in_channel), 64'(0));
        chk("rst_result_data", 64'(bus.result_data), 64'(0));
        chk("rst_result_update", 64'(bus.result_update), 64'(0));
        chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
        chk("rst_ch_ready", 64'(bus.ch_ready), 64'(4'hF));
        @(negedge clk);
        reset = 1'b1;
        tick(2);

        // ---- Free mode: four simultaneous samples, back-to-back issue ----
        for (int i = 0; i < 4; i++) xfer_q.push_back({CW'(i), 16'h7FFF});
        bus.ch_data  = {4{16'h7FFF}};
        bus.ch_valid = 4'hF;
        tick();
        bus.ch_valid = '0;
        chk("t1_valid_before_issue", 64'(bus.fir_in_valid), 64'(0));
        chk("t1_ready_all_full", 64'(bus.ch_ready), 64'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_rdy = 4'((1 << i) - 1);
            chk("t1_valid_consecutive", 64'(bus.fir_in_valid), 64'(1));
            chk("t1_ch_ready", 64'(bus.ch_ready), 64'(exp_rdy));
            tick();
        end
        chk("t1_valid_drained", 64'(bus.fir_in_valid), 64'(0));
        chk("t1_ready_all_free", 64'(bus.ch_ready), 64'(4'hF));

        // ---- Free mode: backpressure holds request stable ----
        bus.fir_in_ready = 1'b0;
        set_ch(2, 16'h0A5C);
        xfer_q.push_back({CW'(2), 16'h0A5C});
        bus.ch_valid = 4'b0100;
        tick();
        bus.ch_valid = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 64'(bus.fir_in_valid), 64'(1));
            chk("t2_hold_channel", 64'(bus.fir_in_channel), 64'(2));
            chk("t2_hold_data", 64'(bus.fir_in_data), 64'(16'h0A5C));
            tick();
        end
        bus.fir_in_ready = 1'b1;
        tick();
        chk("t2_valid_after_xfer", 64'(bus.fir_in_valid), 64'(0));

        // ---- Sync mode: mask 1011, staggered arrivals, ordered burst ----
        bus.sync_mode   = 1'b1;
        bus.enable_mask = 4'b1011;
        tick(2);
        xfer_q.push_back({CW'(0), 16'h8000});
        xfer_q.push_back({CW'(1), 16'h8000});
        xfer_q.push_back({CW'(3), 16'h8000});
        for (int c = 0; c < 8; c++) begin
            bus.ch_valid = '0;
            if (c == 0) begin set_ch(3, 16'h8000); bus.ch_valid = 4'b1000; end
            if (c == 1) begin set_ch(2, 16'h5555); bus.ch_valid = 4'b0100; end
            if (c == 3) begin set_ch(0, 16'h8000); bus.ch_valid = 4'b0001; end
            if (c == 6) begin set_ch(1, 16'h8000); bus.ch_valid = 4'b0010; end
            if (c == 1) chk("t3_disabled_ready", 64'(bus.ch_ready[2]), 64'(1));
            chk("t3_no_valid_before_burst", 64'(bus.fir_in_valid), 64'(0));
            tick();
        end
        bus.ch_valid = '0;
        chk("t3_burst_first_valid", 64'(bus.fir_in_valid), 64'(1));
        chk("t3_burst_first_channel", 64'(bus.fir_in_channel), 64'(0));
        tick(3);
        chk("t3_burst_done_valid", 64'(bus.fir_in_valid), 64'(0));

        // Results return; tag 2 is outside the frame and must not count.
        fir_result(2'd0, 16'h0111);
        tick();
        chk("t3_frame_done_after_0", 64'(bus.frame_done), 64'(0));
        fir_result(2'd2, 16'h0222);
        tick();
        chk("t3_frame_done_after_2", 64'(bus.frame_done), 64'(0));
        fir_result(2'd1, 16'h0333);
        tick();
        chk("t3_frame_done_after_1", 64'(bus.frame_done), 64'(0));
        fir_result(2'd3, 16'h0444);
        tick();
        bus.fir_out_valid = 1'b0;
        chk("t3_frame_done_pulse", 64'(bus.frame_done), 64'(1));
        tick();
        chk("t3_frame_done_clear", 64'(bus.frame_done), 64'(0));

        // ---- Output demux: single result, one-cycle update pulse ----
        fir_result(2'd1, 16'h1234);
        tick();
        bus.fir_out_valid = 1'b0;
        chk("t4_no_frame_done", 64'(bus.frame_done), 64'(0));
        tick();
        chk("t4_update_one_cycle", 64'(bus.result_update), 64'(0));
        chk("t4_result_held", 64'(bus.result_data[1*DW +: DW]), 64'(16'h1234));

        // ---- Round-robin fairness: channels 0 and 1 refilled continuously ----
        bus.sync_mode   = 1'b0;
        bus.enable_mask = 4'hF;
        tick(2);
        set_ch(0, 16'h00C0);
        set_ch(1, 16'h00C1);
        for (int k = 0; k < 3; k++) begin
            xfer_q.push_back({CW'(0), 16'h00C0});
            xfer_q.push_back({CW'(1), 16'h00C1});
        end
        bus.ch_valid = 4'b0011;
        tick(9);
        bus.ch_valid = '0;
        tick(6);
        chk("t5_valid_drained", 64'(bus.fir_in_valid), 64'(0));

        // ---- Reset during a stalled request ----
        bus.fir_in_ready = 1'b0;
        set_ch(3, 16'h0BEE);
        bus.ch_valid = 4'b1000;
        tick();
        bus.ch_valid = '0;
        tick();
        chk("t6_valid_before_reset", 64'(bus.fir_in_valid), 64'(1));
        chk("t6_channel_before_reset", 64'(bus.fir_in_channel), 64'(3));
        reset = 1'b0;
        #1;
        chk("t6_valid_async_drop", 64'(bus.fir_in_valid), 64'(0));
        chk("t6_data_cleared", 64'(bus.fir_in_data), 64'(0));
        chk("t6_results_cleared", 64'(bus.result_data), 64'(0));
        chk("t6_slots_cleared", 64'(bus.ch_ready), 64'(4'hF));
        @(negedge clk);
        reset = 1'b1;
        bus.fir_in_ready = 1'b1;
        tick(5);
        chk("t6_no_xfer_after_reset", 64'(bus.fir_in_valid), 64'(0));

        // ---- All expectations consumed ----
        chk("xfer_queue_empty", 64'(xfer_q.size()), 64'(0));
        chk("result_queue_empty", 64'(res_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
